// File: rtl/sevenseg_capture_if.sv
// Display-side bundle for sevenseg_capture: the driver's segment/anode lines
// plus the digit-store read port. master = stimulus/driver side,
// slave = the capture block.
interface sevenseg_capture_if;
  logic       segA, segB, segC, segD, segE, segF, segG;
  logic       an0, an1, an2, an3, an4, an5, an6, an7;
  logic [2:0] rd_sel;
  logic [3:0] rd_num;
  logic       rd_valid;
  logic       all_valid;
  logic       frame_done;
  logic       err;
  logic [2:0] err_digit;

  modport master (
    output segA, segB, segC, segD, segE, segF, segG,
    output an0, an1, an2, an3, an4, an5, an6, an7,
    output rd_sel,
    input  rd_num, rd_valid, all_valid, frame_done, err, err_digit
  );

  modport slave (
    input  segA, segB, segC, segD, segE, segF, segG,
    input  an0, an1, an2, an3, an4, an5, an6, an7,
    input  rd_sel,
    output rd_num, rd_valid, all_valid, frame_done, err, err_digit
  );
endinterface

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: watches a multiplexed 8-digit seven-segment display and
// rebuilds the hex value shown on each digit into an 8-entry store.
//   clk    : sampling clock (rising edge)
//   reset  : asynchronous, active-low
//   bus    : segA..segG / an0..an7 in, rd_sel in; rd_num, rd_valid,
//            all_valid, frame_done, err, err_digit out
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic               clk,
  input logic               reset,
  sevenseg_capture_if.slave bus
);

  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

  logic [6:0]      seg_raw, seg;
  logic [7:0]      an_raw, an;
  logic [2:0]      an_idx;
  logic            qualified, same;
  logic [4:0]      dec;

  logic [6:0]      prev_seg_q, prev_seg_d;
  logic [7:0]      prev_an_q, prev_an_d;
  logic [3:0]      run_q, run_d;
  logic [7:0][3:0] digit_q, digit_d;
  logic [7:0]      valid_q, valid_d;
  logic [7:0]      seen_q, seen_d;
  logic            err_q, err_d;
  logic [2:0]      err_digit_q, err_digit_d;
  logic            frame_done_q, frame_done_d;

  // Returns {ok, value}; ok = 0 for any pattern outside the hex font.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign seg_raw = {bus.segG, bus.segF, bus.segE, bus.segD, bus.segC, bus.segB, bus.segA};
  assign an_raw  = {bus.an7, bus.an6, bus.an5, bus.an4, bus.an3, bus.an2, bus.an1, bus.an0};
  assign seg     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign an      = AN_ACTIVE_LOW  ? ~an_raw  : an_raw;

  assign qualified = (seg != '0) && $onehot(an);
  assign same      = (seg == prev_seg_q) && (an == prev_an_q);
  assign dec       = decode(seg);

  always_comb begin
    an_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (an[i]) an_idx = 3'(i);
    end
  end

  always_comb begin
    logic       capture;
    logic [7:0] seen_next;

    prev_seg_d   = seg;
    prev_an_d    = an;
    digit_d      = digit_q;
    valid_d      = valid_q;
    seen_d       = seen_q;
    err_d        = 1'b0;
    err_digit_d  = err_digit_q;
    frame_done_d = 1'b0;
    seen_next    = seen_q;

    if (qualified && same)  run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
    else if (qualified)     run_d = 4'd1;
    else                    run_d = '0;

    // Fires only on the STABLE_CYCLES-1 -> STABLE_CYCLES step, so a held
    // pattern sitting at the saturated count never recaptures.
    capture = qualified && same && (run_q == RUN_MAX - 4'd1);

    if (capture) begin
      if (dec[4]) begin
        digit_d[an_idx] = dec[3:0];
        valid_d[an_idx] = 1'b1;
        seen_next       = seen_q | (8'd1 << an_idx);
        if (seen_next == '1) begin
          frame_done_d = 1'b1;
          seen_d       = '0;
        end else begin
          seen_d = seen_next;
        end
      end else begin
        valid_d[an_idx] = 1'b0;
        err_d           = 1'b1;
        err_digit_d     = an_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_seg_q   <= '0;
      prev_an_q    <= '0;
      run_q        <= '0;
      digit_q      <= '0;
      valid_q      <= '0;
      seen_q       <= '0;
      err_q        <= 1'b0;
      err_digit_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      prev_seg_q   <= prev_seg_d;
      prev_an_q    <= prev_an_d;
      run_q        <= run_d;
      digit_q      <= digit_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      err_q        <= err_d;
      err_digit_q  <= err_digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.rd_num     = digit_q[bus.rd_sel];
  assign bus.rd_valid   = valid_q[bus.rd_sel];
  assign bus.all_valid  = &valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;
  assign bus.err_digit  = err_digit_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
module tb_sevenseg_capture;

  localparam int S = 4;

  logic clk;
  logic reset;
  sevenseg_capture_if ifc ();

  sevenseg_capture #(
    .STABLE_CYCLES (S),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int cur_sel = 0;
  int err_cnt = 0;
  int frame_cnt = 0;

  // Reference model: the hex font as a lookup array, and a sliding window of
  // the samples seen since reset.
  logic [6:0]  font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [14:0] hist [$];
  int          m_digit [8];
  bit          m_valid [8];
  bit          m_seen  [8];
  bit          m_err;
  int          m_err_digit;
  bit          m_frame;

  typedef struct {
    logic [6:0] seg;
    int         dig;
    int         num;
    int         frame;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < 8; i++) begin
      m_digit[i] = 0;
      m_valid[i] = 0;
      m_seen[i]  = 0;
    end
    m_err = 0;
    m_err_digit = 0;
    m_frame = 0;
  endtask

  function automatic int font_value(input logic [6:0] s);
    for (int v = 0; v < 16; v++) if (font[v] == s) return v;
    return -1;
  endfunction

  // A digit is captured when the last S samples are one identical lit,
  // single-anode sample and the sample before them differs (or predates reset).
  task automatic model_step(input logic [6:0] s, input logic [7:0] a);
    logic [14:0] cur;
    bit cap;
    int n, idx, v;
    bit all;
    cur = {s, a};
    m_err = 0;
    m_frame = 0;
    hist.push_back(cur);
    if (hist.size() > S + 1) hist.delete(0);
    n = hist.size();
    cap = (s != 0) && ($countones(a) == 1) && (n >= S);
    if (cap) for (int k = n - S; k < n; k++) if (hist[k] != cur) cap = 0;
    if (cap && n == S + 1 && hist[0] == cur) cap = 0;
    if (cap) begin
      idx = 0;
      for (int i = 0; i < 8; i++) if (a[i]) idx = i;
      v = font_value(s);
      if (v >= 0) begin
        m_digit[idx] = v;
        m_valid[idx] = 1;
        m_seen[idx]  = 1;
        all = 1;
        for (int i = 0; i < 8; i++) if (!m_seen[i]) all = 0;
        if (all) begin
          m_frame = 1;
          for (int i = 0; i < 8; i++) m_seen[i] = 0;
        end
      end else begin
        m_valid[idx] = 0;
        m_err = 1;
        m_err_digit = idx;
      end
    end
  endtask

  function automatic int model_all_valid();
    for (int i = 0; i < 8; i++) if (!m_valid[i]) return 0;
    return 1;
  endfunction

  task automatic drive(input logic [6:0] s, input logic [7:0] a);
    logic [6:0] rs;
    logic [7:0] ra;
    rs = ~s;
    ra = ~a;
    ifc.segA = rs[0]; ifc.segB = rs[1]; ifc.segC = rs[2]; ifc.segD = rs[3];
    ifc.segE = rs[4]; ifc.segF = rs[5]; ifc.segG = rs[6];
    ifc.an0 = ra[0]; ifc.an1 = ra[1]; ifc.an2 = ra[2]; ifc.an3 = ra[3];
    ifc.an4 = ra[4]; ifc.an5 = ra[5]; ifc.an6 = ra[6]; ifc.an7 = ra[7];
  endtask

  task automatic tick(input logic [6:0] s, input logic [7:0] a);
    drive(s, a);
    ifc.rd_sel = 3'(cur_sel);
    @(posedge clk);
    model_step(s, a);
    #1;
    chk("err", int'(ifc.err), int'(m_err));
    chk("err_digit", int'(ifc.err_digit), m_err_digit);
    chk("frame_done", int'(ifc.frame_done), int'(m_frame));
    chk("all_valid", int'(ifc.all_valid), model_all_valid());
    chk("rd_num", int'(ifc.rd_num), m_digit[cur_sel]);
    chk("rd_valid", int'(ifc.rd_valid), int'(m_valid[cur_sel]));
    err_cnt   += int'(ifc.err);
    frame_cnt += int'(ifc.frame_done);
  endtask

  task automatic hold(input logic [6:0] s, input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) tick(s, a);
  endtask

  task automatic do_reset();
    drive(7'h00, 8'h00);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("reset_rd_num", int'(ifc.rd_num), 0);
    chk("reset_rd_valid", int'(ifc.rd_valid), 0);
    chk("reset_all_valid", int'(ifc.all_valid), 0);
    chk("reset_err", int'(ifc.err), 0);
    chk("reset_err_digit", int'(ifc.err_digit), 0);
    chk("reset_frame_done", int'(ifc.frame_done), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cur_sel = 0;
    ifc.rd_sel = 3'd0;
    drive(7'h00, 8'h00);
    model_clear();

    tbl[0] = '{7'h79, 0, 14, 0};
    tbl[1] = '{7'h5E, 1, 13, 0};
    tbl[2] = '{7'h39, 2, 12, 0};
    tbl[3] = '{7'h7C, 3, 11, 0};
    tbl[4] = '{7'h77, 4, 10, 0};
    tbl[5] = '{7'h6F, 5,  9, 0};
    tbl[6] = '{7'h06, 6,  1, 0};
    tbl[7] = '{7'h3F, 7,  0, 1};

    do_reset();

    // Single capture, then a long hold must not recapture or error.
    cur_sel = 0;
    err_cnt = 0;
    hold(7'h06, 8'h01, 3);
    chk("single_before_capture", int'(ifc.rd_valid), 0);
    tick(7'h06, 8'h01);
    chk("single_rd_num", int'(ifc.rd_num), 1);
    chk("single_rd_valid", int'(ifc.rd_valid), 1);
    hold(7'h06, 8'h01, 10);
    chk("single_hold_err", err_cnt, 0);
    chk("single_hold_valid", int'(ifc.rd_valid), 1);

    // Glitch rejection: a short 8 before a stable 9.
    cur_sel = 3;
    hold(7'h7F, 8'h08, 3);
    chk("glitch_no_8", int'(ifc.rd_valid), 0);
    hold(7'h6F, 8'h08, 4);
    chk("glitch_rd_num", int'(ifc.rd_num), 9);
    chk("glitch_rd_valid", int'(ifc.rd_valid), 1);

    // Undecodable pattern on a digit already holding 3.
    cur_sel = 2;
    tick(7'h00, 8'h00);
    hold(7'h4F, 8'h04, 4);
    chk("inv_pre_num", int'(ifc.rd_num), 3);
    tick(7'h00, 8'h00);
    err_cnt = 0;
    hold(7'h01, 8'h04, 6);
    chk("inv_err_pulses", err_cnt, 1);
    chk("inv_err_digit", int'(ifc.err_digit), 2);
    chk("inv_rd_valid", int'(ifc.rd_valid), 0);
    chk("inv_rd_num_kept", int'(ifc.rd_num), 3);

    // Full frame from the table.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      cur_sel = tbl[r].dig;
      frame_cnt = 0;
      hold(tbl[r].seg, 8'(1 << tbl[r].dig), 4);
      chk("frame_row_num", int'(ifc.rd_num), tbl[r].num);
      chk("frame_row_pulse", frame_cnt, tbl[r].frame);
      frame_cnt = 0;
      tick(7'h00, 8'h00);
      chk("frame_blank_pulse", frame_cnt, 0);
    end
    chk("frame_all_valid", int'(ifc.all_valid), 1);
    for (int r = 0; r < 8; r++) begin
      cur_sel = tbl[r].dig;
      tick(7'h00, 8'h00);
      chk("frame_readback", int'(ifc.rd_num), tbl[r].num);
    end

    // Two anodes, then none: nothing may happen.
    cur_sel = 0;
    err_cnt = 0;
    frame_cnt = 0;
    hold(7'h3F, 8'h03, 8);
    hold(7'h3F, 8'h00, 2);
    chk("multi_err", err_cnt, 0);
    chk("multi_frame", frame_cnt, 0);
    chk("multi_all_valid", int'(ifc.all_valid), 1);
    chk("multi_rd_num", int'(ifc.rd_num), 14);

    // Anode switch with constant segments starts a new run.
    cur_sel = 6;
    hold(7'h66, 8'h20, 2);
    hold(7'h66, 8'h40, 3);
    chk("switch_no_capture", int'(ifc.rd_num), 1);
    tick(7'h66, 8'h40);
    chk("switch_capture", int'(ifc.rd_num), 4);

    // Reset mid-run.
    cur_sel = 5;
    tick(7'h00, 8'h00);
    hold(7'h66, 8'h20, 2);
    reset = 1'b0;
    #2;
    model_clear();
    chk("midrst_rd_valid", int'(ifc.rd_valid), 0);
    chk("midrst_rd_num", int'(ifc.rd_num), 0);
    chk("midrst_all_valid", int'(ifc.all_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    hold(7'h66, 8'h20, 3);
    chk("midrst_no_capture", int'(ifc.rd_valid), 0);
    tick(7'h66, 8'h20);
    chk("midrst_capture_num", int'(ifc.rd_num), 4);
    chk("midrst_capture_valid", int'(ifc.rd_valid), 1);

    // Randomized traffic against the model.
    for (int t = 0; t < 600; t++) begin
      int kind, dur, d;
      logic [6:0] s;
      logic [7:0] a;
      kind = $urandom_range(0, 9);
      dur  = $urandom_range(1, 6);
      d    = $urandom_range(0, 7);
      a    = 8'(1 << d);
      s    = font[$urandom_range(0, 15)];
      if (kind == 0) a = 8'h00;
      else if (kind == 1) a = a | 8'(1 << $urandom_range(0, 7));
      else if (kind == 2) s = 7'($urandom_range(0, 127));
      for (int i = 0; i < dur; i++) begin
        cur_sel = $urandom_range(0, 7);
        tick(s, a);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive-side companion to the team's 8-digit multiplexed seven-segment display driver.
- Watches the driver's segment lines (segA..segG) and anode lines (an0..an7).
- Reconstructs the 4-bit hex value shown on each digit and holds it in an 8-entry digit store.
- The store has a random-access read port, so testbenches and self-check logic can confirm what the display actually shows.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured; legal range 2..15.
- SEG_ACTIVE_LOW, 1: segment inputs are active-low when 1.
- AN_ACTIVE_LOW, 1: anode inputs are active-low when 1.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- reset  input  1  asynchronous, active-low reset.
- segA..segG  input  1 each  segment lines from the display driver.
- an0..an7  input  1 each  digit-enable (anode) lines from the display driver.
- rd_sel  input  3  digit index to read.
- rd_num  output  4  captured value of digit rd_sel; combinational from the store.
- rd_valid  output  1  digit rd_sel has been captured since reset; combinational.
- all_valid  output  1  all 8 valid bits set.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the previous pulse or reset.
- err  output  1  one-cycle pulse: a stable, lit pattern did not decode.
- err_digit  output  3  index of the digit that caused the last err; held until the next err.

Behaviour:
- Normalisation:
  - Inputs are inverted per the polarity parameters.
  - seg = {G,F,E,D,C,B,A}, bit0 = A, 1 = lit.
  - an = {an7..an0}, 1 = enabled.
- Sample registers prev_seg[6:0] and prev_an[7:0] load every edge; reset value 0.
- A sample is "qualified" when an is exactly one-hot and seg != 0. Blank digits and inter-digit dead time are not qualified.
- Run counter run[3:0]:
  - At each edge, if the current sample is qualified and equals prev (seg and an), run <= sat(run+1, STABLE_CYCLES).
  - Else if qualified, run <= 1.
  - Else run <= 0.
- Capture happens at the edge where run goes from STABLE_CYCLES-1 to STABLE_CYCLES, exactly once per run. A held pattern never recaptures.
  - Latency: inputs applied before edge k are captured at edge k+STABLE_CYCLES-1 and visible on rd_num right after that edge.
- Decode table (seg hex -> value):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7.
  - 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F.
- Capture of a decodable pattern on digit i:
  - digit[i] <= value; valid[i] <= 1; seen[i] <= 1.
- Capture of any other pattern on digit i:
  - digit[i] unchanged; valid[i] <= 0; seen[i] unchanged.
  - err pulses 1 cycle; err_digit <= i.
- Frame tracking:
  - When the seen mask would become 8'hFF, frame_done pulses at that edge and seen clears to 0 at the same edge.
  - A capture on that same edge from a different digit cannot occur (one anode per sample).
- Zero or multiple anodes enabled: no capture, no error, run cleared.
- Anode switching while seg holds constant counts as a new run.
- Outputs after reset:
  - digit[*]=0, valid=0, seen=0, run=0, err=0, err_digit=0, frame_done=0.
  - rd_num=0, rd_valid=0, all_valid=0.
- Reset asserted mid-run clears everything immediately (asynchronous). After release, the run restarts from zero.
- Read port is purely combinational. A simultaneous capture to digit rd_sel appears on rd_num the cycle after the capturing edge.

Test Plan:
- Reset then single capture: reset low 2 cycles; drive an0 active, seg=06 for 4 edges -> after 4th edge digit0=1, rd_sel=0 gives rd_num=1, rd_valid=1; held 10 more edges -> no further captures, no err.
- Glitch rejection: an3 active with seg=7F for 3 edges, then seg=6F for 4 edges -> digit3=9 only; 8 never stored.
- Invalid pattern: digit2 holds 4F (3); then an2 with seg=01 for 4 edges -> err pulses once, err_digit=2, valid[2]=0, rd_num at sel 2 still 3.
- Full frame: drive digits 0..7 with E,D,C,B,A,9,1,0 (79,5E,39,7C,77,6F,06,3F), 4 edges each, 1 blank cycle between digits -> frame_done pulses once at the capture of digit 7; all_valid=1; readback matches per digit.
- Multi/zero anode: an0 and an1 enabled together with seg=3F for 8 edges, then all anodes off -> no capture, no err, valid unchanged.
- Reset mid-run: digit5 seg=66 for 2 edges; assert reset; release; hold 3 more edges -> no capture; 4th edge after release captures 4.
